// File: rtl/gf_exp_pkg.sv
// Shared types and constants for the GF(2^m) exponentiation engine.
package gf_exp_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int EXP_WIDTH_DEF  = 16;
  localparam int GRADE_W = $clog2(DATA_WIDTH_DEF) + 1;
  localparam int ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    MULT,
    DONE
  } state_t;

endpackage

// File: rtl/gf_mulred.sv
// Combinational GF(2^m) multiply: carry-less product then reduction by p(x).
module gf_mulred #(
  parameter int DATA_WIDTH = 16,
  parameter int GW = $clog2(DATA_WIDTH) + 1
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [GW-1:0]         polyn_grade,
  input  logic [DATA_WIDTH:0]   polyn_red_in,
  output logic [DATA_WIDTH-1:0] out
);

  localparam int PW = 2 * DATA_WIDTH - 1;

  logic [PW-1:0] prod;
  logic [PW-1:0] rem;
  logic [PW-1:0] red_ext;

  always_comb begin
    prod = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (b[i]) begin
        prod = prod ^ (PW'(a) << i);
      end
    end
  end

  // Top-down so each fold can only touch bits below the one it clears.
  always_comb begin
    rem     = prod;
    red_ext = PW'(polyn_red_in);
    for (int k = PW - 1; k >= 0; k--) begin
      if (k >= int'(polyn_grade) && rem[k]) begin
        rem = rem ^ (red_ext << (k - int'(polyn_grade)));
      end
    end
    out = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(polyn_grade)) begin
        out[i] = rem[i];
      end
    end
  end

endmodule

// File: rtl/gf_exp_seq.sv
// Sequential GF(2^m) exponentiation, left-to-right square-and-multiply.
// GF_EXP_SKIP_LZ_EN: start the scan at the exponent's most significant one.
module gf_exp_seq
  import gf_exp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int EXP_WIDTH  = EXP_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       base,
  input  logic [EXP_WIDTH-1:0]        exponent,
  input  logic [$clog2(DATA_WIDTH):0] polyn_grade,
  input  logic [DATA_WIDTH:0]         polyn_red_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       result,
  output logic                        busy
);

  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] base_r;
  logic [DATA_WIDTH-1:0] base_m;
  logic [DATA_WIDTH-1:0] mr_b;
  logic [DATA_WIDTH-1:0] mr_out;
  logic [EXP_WIDTH-1:0]  exp_r;
  logic [GW-1:0]         grade_r;
  logic [DATA_WIDTH:0]   red_r;
  logic [IW-1:0]         idx;
  logic                  grade_ok;

  function automatic logic legal(input logic [GW-1:0] g);
    return (int'(g) >= 2) && (int'(g) <= DATA_WIDTH);
  endfunction

`ifdef GF_EXP_SKIP_LZ_EN
  function automatic logic [IW-1:0] msb_idx(
    input logic [EXP_WIDTH-1:0] e
  );
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < EXP_WIDTH; i++) begin
      if (e[i]) begin
        r = IW'(i);
      end
    end
    return r;
  endfunction
`endif

  assign grade_ok = legal(grade_r);
  assign mr_b     = (state == MULT) ? base_r : acc;

  always_comb begin
    base_m = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(polyn_grade)) begin
        base_m[i] = base[i];
      end
    end
  end

  gf_mulred #(
    .DATA_WIDTH (DATA_WIDTH),
    .GW         (GW)
  ) u_mulred (
    .a            (acc),
    .b            (mr_b),
    .polyn_grade  (grade_r),
    .polyn_red_in (red_r),
    .out          (mr_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      base_r    <= '0;
      exp_r     <= '0;
      grade_r   <= '0;
      red_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            base_r   <= base_m;
            exp_r    <= exponent;
            grade_r  <= polyn_grade;
            red_r    <= polyn_red_in;
            acc      <= DATA_WIDTH'(ONE);
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef GF_EXP_SKIP_LZ_EN
            if (exponent == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= legal(polyn_grade) ?
                           DATA_WIDTH'(ONE) : '0;
            end else begin
              idx   <= msb_idx(exponent);
              state <= SQUARE;
            end
`else
            idx   <= IW'(EXP_WIDTH - 1);
            state <= SQUARE;
`endif
          end
        end
        SQUARE: begin
          acc <= mr_out;
          if (exp_r[idx]) begin
            state <= MULT;
          end else if (idx == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= grade_ok ? mr_out : '0;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        MULT: begin
          acc <= mr_out;
          if (idx == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= grade_ok ? mr_out : '0;
          end else begin
            idx   <= idx - 1'b1;
            state <= SQUARE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_exp_seq.sv
// Randomized bench for gf_exp_seq against a shift-and-add GF(2^m) model.
module tb_gf_exp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] base = '0;
  logic [15:0] exponent = '0;
  logic [4:0]  polyn_grade = '0;
  logic [16:0] polyn_red_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        busy;

  gf_exp_seq #(
    .DATA_WIDTH (16),
    .EXP_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .base         (base),
    .exponent     (exponent),
    .polyn_grade  (polyn_grade),
    .polyn_red_in (polyn_red_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  bit          exp_valid = 0;
  bit          lat_done = 0;
  int unsigned exp_res = 0;
  int          exp_lat = 0;
  int          acc_cyc = 0;
  int          rdy_mode = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
               name, act, act, req, req, $time);
    end
  endtask

  function automatic int unsigned gmul(input int unsigned a,
                                       input int unsigned b,
                                       input int m,
                                       input int unsigned p);
    int unsigned mask, r, x;
    mask = (32'd1 << m) - 1;
    x = a & mask;
    r = 0;
    for (int i = 0; i < m; i++) begin
      if (b[i]) r = r ^ x;
      x = x << 1;
      if (x[m]) x = x ^ p;
    end
    return r & mask;
  endfunction

  function automatic int unsigned gpow(input int unsigned b,
                                       input int unsigned e,
                                       input int m,
                                       input int unsigned p);
    int unsigned r, s;
    if (m < 2 || m > 16) return 0;
    r = 1;
    s = b & ((32'd1 << m) - 1);
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = gmul(r, s, m, p);
      s = gmul(s, s, m, p);
    end
    return r;
  endfunction

  function automatic int glat(input int unsigned e);
    int pop, msb;
    pop = 0;
    msb = -1;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) begin
        pop++;
        msb = i;
      end
    end
`ifdef GF_EXP_SKIP_LZ_EN
    if (msb < 0) return 1;
    return msb + 1 + pop;
`else
    return 16 + pop;
`endif
  endfunction

  // Single compare process: result/handshake every cycle out_valid is high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (!exp_valid) begin
          chk("spurious_out_valid", int'(out_valid), 0);
        end else begin
          chk("result", int'(result), int'(exp_res));
          chk("in_ready_in_done", int'(in_ready), 0);
          chk("busy_in_done", int'(busy), 1);
          if (!lat_done) begin
            chk("latency", cyc - acc_cyc, exp_lat);
            lat_done = 1;
          end
        end
      end
      if (rdy_mode == 1) out_ready = 1'b0;
      else if (rdy_mode == 2) out_ready = 1'b1;
      else out_ready = ($urandom_range(3) != 0);
      if (out_valid && out_ready) begin
        exp_valid = 0;
        lat_done = 0;
      end
    end
  end

  task automatic issue(input logic [15:0] b, input logic [15:0] e,
                       input int m, input int p);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", n, 0);
    base = b;
    exponent = e;
    polyn_grade = 5'(m);
    polyn_red_in = 17'(p);
    in_valid = 1'b1;
    exp_res = gpow(32'(b), 32'(e), m, 32'(p));
    exp_lat = glat(32'(e));
    acc_cyc = cyc + 1;
    lat_done = 0;
    exp_valid = 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_valid || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("done_timeout", n, 0);
      exp_valid = 0;
    end
  endtask

  task automatic run(input logic [15:0] b, input logic [15:0] e,
                     input int m, input int p);
    issue(b, e, m, p);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int fm[6] = '{2, 3, 4, 5, 8, 16};
  int fp[6] = '{7, 11, 19, 37, 285, 'h1100B};

  initial begin
    chk("model_2^4_m4", int'(gpow(2, 4, 4, 19)), 3);
    chk("model_2^15_m4", int'(gpow(2, 15, 4, 19)), 1);
    chk("model_inv7_m4", int'(gmul(7, gpow(7, 14, 4, 19), 4, 19)), 1);
    chk("model_2^8_m8", int'(gpow(2, 8, 8, 285)), 29);
    chk("model_2^255_m8", int'(gpow(2, 255, 8, 285)), 1);
    chk("model_0^0", int'(gpow(0, 0, 8, 285)), 1);
    chk("model_0^5", int'(gpow(0, 5, 8, 285)), 0);
`ifdef GF_EXP_SKIP_LZ_EN
    chk("model_lat_e4", glat(4), 4);
    chk("model_lat_e0", glat(0), 1);
`else
    chk("model_lat_e4", glat(4), 17);
    chk("model_lat_e0", glat(0), 16);
`endif

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(16'd2, 16'd4, 4, 19);
    run(16'd2, 16'd15, 4, 19);
    run(16'd7, 16'd14, 4, 19);
    run(16'd2, 16'd8, 8, 285);
    run(16'd2, 16'd255, 8, 285);
    run(16'd5, 16'd0, 8, 285);
    run(16'd0, 16'd0, 8, 285);
    run(16'd0, 16'd5, 8, 285);
    run(16'hFFF3, 16'd9, 4, 19);
    run(16'hBEEF, 16'hFFFF, 16, 'h1100B);
    run(16'd3, 16'd7, 1, 3);
    run(16'd3, 16'd7, 17, 'h1FFFF);
    run(16'd3, 16'd0, 20, 19);

    // Backpressure: result held, extra requests ignored.
    rdy_mode = 1;
    issue(16'd3, 16'h00A5, 8, 285);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) chk("bp_valid_timeout", n, 0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      base = 16'($urandom);
      exponent = 16'($urandom);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    rdy_mode = 2;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("rel_out_valid", int'(out_valid), 0);
    chk("rel_in_ready", int'(in_ready), 1);
    chk("rel_busy", int'(busy), 0);
    @(negedge clk);
    chk("rel_idle_busy", int'(busy), 0);
    rdy_mode = 0;

    // Asynchronous reset while in MULT.
    issue(16'd3, 16'h8001, 8, 285);
    @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    exp_valid = 0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(16'd7, 16'd14, 4, 19);

    for (int t = 0; t < 40; t++) begin
      int f;
      logic [15:0] e;
      f = int'($urandom_range(5));
      case ($urandom_range(3))
        0: e = 16'($urandom_range(7));
        1: e = ($urandom_range(1) != 0) ? 16'hFFFF : 16'h8000;
        default: e = 16'($urandom);
      endcase
      run(16'($urandom), e, fm[f], fp[f]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
